// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command controller: FSM encoding, default opcodes
// and a saturating counter helper.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WDATA   = 3'd2,
    ST_RDATA   = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  localparam logic [7:0] OP_WRITE_DEF = 8'h01;
  localparam logic [7:0] OP_READ_DEF  = 8'h02;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: turns a received opcode/address/data byte stream into
// register-bus write and read strobes, returning read data to the SPI transmitter.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter logic [7:0]  OP_WRITE = OP_WRITE_DEF,
  parameter logic [7:0]  OP_READ  = OP_READ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel_active,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rd_mode;
  logic              w_rd_mode_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_rdata_vld;
  logic              w_rdata_vld_nxt;

  logic [ADDR_W-1:0] w_reg_addr_nxt;
  logic [7:0]        w_reg_wdata_nxt;
  logic              w_reg_we_nxt;
  logic              w_reg_re_nxt;
  logic [7:0]        w_tx_byte_nxt;
  logic              w_tx_load_nxt;
  logic              w_busy_nxt;
  logic [7:0]        w_err_cnt_nxt;

  logic              w_rx;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_rx_addr;

  assign w_rx       = rx_valid & ssel_active;
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_rx_addr  = rx_byte[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next registered outputs; frame end wins over everything
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_mode_nxt   = r_rd_mode;
    w_addr_nxt      = r_addr;
    w_reg_addr_nxt  = reg_addr;
    w_reg_wdata_nxt = reg_wdata;
    w_reg_we_nxt    = 1'b0;
    w_reg_re_nxt    = 1'b0;
    w_tx_byte_nxt   = tx_byte;
    w_tx_load_nxt   = 1'b0;
    w_err_cnt_nxt   = err_cnt;
    w_rdata_vld_nxt = 1'b0;

    if (!ssel_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      // Read data arrives the cycle after reg_re; forward it to the transmitter
      if (r_rdata_vld) begin
        w_tx_byte_nxt = reg_rdata;
        w_tx_load_nxt = 1'b1;
      end
      w_rdata_vld_nxt = reg_re;

      unique case (r_state)
        ST_IDLE: begin
          if (w_rx) begin
            if (rx_byte == OP_WRITE) begin
              w_state_nxt   = ST_ADDR;
              w_rd_mode_nxt = 1'b0;
            end else if (rx_byte == OP_READ) begin
              w_state_nxt   = ST_ADDR;
              w_rd_mode_nxt = 1'b1;
            end else begin
              w_state_nxt   = ST_DISCARD;
              w_err_cnt_nxt = sat_inc8(err_cnt);
            end
          end
        end
        ST_ADDR: begin
          if (w_rx) begin
            w_addr_nxt     = w_rx_addr;
            w_reg_addr_nxt = w_rx_addr;
            if (r_rd_mode) begin
              w_state_nxt  = ST_RDATA;
              w_reg_re_nxt = 1'b1;
            end else begin
              w_state_nxt  = ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (w_rx) begin
            w_reg_we_nxt    = 1'b1;
            w_reg_wdata_nxt = rx_byte;
            w_reg_addr_nxt  = r_addr;
            w_addr_nxt      = w_addr_inc;
          end
        end
        ST_RDATA: begin
          // Each dummy byte advances the address and fetches the next register
          if (w_rx) begin
            w_addr_nxt     = w_addr_inc;
            w_reg_addr_nxt = w_addr_inc;
            w_reg_re_nxt   = 1'b1;
          end
        end
        ST_DISCARD: begin
          w_state_nxt = ST_DISCARD;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_mode   <= 1'b0;
      r_addr      <= '0;
      r_rdata_vld <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= 8'h00;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      tx_byte     <= 8'h00;
      tx_load     <= 1'b0;
      busy        <= 1'b0;
      err_cnt     <= 8'h00;
    end else begin
      r_rd_mode   <= w_rd_mode_nxt;
      r_addr      <= w_addr_nxt;
      r_rdata_vld <= w_rdata_vld_nxt;
      reg_addr    <= w_reg_addr_nxt;
      reg_wdata   <= w_reg_wdata_nxt;
      reg_we      <= w_reg_we_nxt;
      reg_re      <= w_reg_re_nxt;
      tx_byte     <= w_tx_byte_nxt;
      tx_load     <= w_tx_load_nxt;
      busy        <= w_busy_nxt;
      err_cnt     <= w_err_cnt_nxt;
    end
  end

endmodule
